shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Iterative, DSP-free integer multiplier. Forms the full product a*b of two operands already reduced mod Q = 8380417.
- Sits directly upstream of the 48-bit-input modular reduction stage. product_out/done drive that stage's data_in/start without glue.
- Processes RADIX_BITS multiplier bits per cycle using only shifts and adds, with a start/done handshake.

Parameters:
- A_WIDTH, 23, multiplicand width (Q_WIDTH).
- B_WIDTH, 23, multiplier width (Q_WIDTH).
- PROD_WIDTH, 48, product/accumulator width (DATA_WIDTH of downstream stage); must be >= A_WIDTH+B_WIDTH+2.
- RADIX_BITS, 2, multiplier bits consumed per iteration (1 or 2 supported).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- a_in  in  A_WIDTH  multiplicand, captured on accepted start
- b_in  in  B_WIDTH  multiplier, captured on accepted start
- busy  out  1  high in MULT and FINISH
- done  out  1  one-cycle pulse; product_out valid while high and held until next done
- product_out  out  PROD_WIDTH  zero-extended a*b

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; done, busy, product_out, acc, a_sh, b_sh, iter all 0. Applies mid-operation: an in-flight multiply is discarded and no done is produced.
- States: IDLE, MULT, FINISH.
- IDLE:
  - done<=0.
  - If start: a_sh<=zero-extended a_in (PROD_WIDTH), b_sh<=b_in, acc<=0, iter<=0, go to MULT.
- MULT, each cycle:
  - d = b_sh[RADIX_BITS-1:0].
  - Partial product pp = 0, a_sh, a_sh<<1, or (a_sh<<1)+a_sh for d = 0..3. No multiply operator.
  - acc<=acc+pp; a_sh<=a_sh<<RADIX_BITS; b_sh<=b_sh>>RADIX_BITS; iter<=iter+1.
  - On the last iteration (iter==N-1, N=ceil(B_WIDTH/RADIX_BITS), 12 by default), go to FINISH.
- FINISH: product_out<=acc; done<=1; go to IDLE.
- Latency: start sampled at edge E, so done is high in the cycle following edge E+N+1 (E+13 by default). Throughput is one product per N+2 cycles.
- start while busy: ignored, with no effect on the operation or operands.
- start while done is high (state already IDLE): accepted, giving back-to-back operation.
- a_in/b_in are don't-care except on the accepting edge.
- Arithmetic is unsigned. The accumulator never overflows given the width rule. Operands >= Q are multiplied exactly; no range error is raised.

Optional Feature:
- Macro: SHIFT_ADD_MULT_EARLY_TERM_EN.
- Defined: MULT also exits to FINISH when b_sh>>RADIX_BITS == 0 after the current iteration. Latency becomes data-dependent (minimum: done at E+2 for b_in<4 with RADIX_BITS=2). Product values are unchanged.
- Undefined: fixed N-iteration latency as above.

Decomposition:
- Shared package mod_arith_pkg holds:
  - Q=8380417, Q_WIDTH=23, DATA_WIDTH=48
  - state typedef/encodings (IDLE/MULT/FINISH)
  - the iteration-count function ceil(B_WIDTH/RADIX_BITS)
- One natural sub-module: pp_select. It is combinational and maps digit d and a_sh to pp. It is shared with future radix variants.

Test Plan:
- a=3, b=5, start one cycle -> busy rises next cycle; done pulses once at E+13; product_out=15; done low the following cycle.
- a=8388607, b=8388607 -> product_out=70368727400449; a=8380416, b=8380416 -> 70231372333056.
- a=0, b=8380416, and a=8380416, b=0 -> product_out=0. With the early-term macro defined, b=0 gives done at E+2.
- Back-to-back:
  - start with (a=7, b=9), then start asserted again during its done cycle with (a=2, b=11).
  - Required: products 63 then 22; done pulses separated by exactly N+2 cycles.
- Ignored start and mid-operation reset:
  - start asserted with new operands at cycle E+5 -> ignored; the original product is still correct.
  - rst_n low at E+6 -> done never pulses; all outputs 0.
  - After reset release, a fresh start (a=4, b=4) gives 16.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared modular-arithmetic constants, FSM states and iteration helper
package mod_arith_pkg;

  localparam int Q          = 8380417;
  localparam int Q_WIDTH    = 23;
  localparam int DATA_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Number of shift-add iterations needed to consume every multiplier bit.
  function automatic int iter_count(input int b_width, input int radix_bits);
    return (b_width + radix_bits - 1) / radix_bits;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_pp_select.sv
// rtl/shift_add_multiplier_pp_select.sv - partial-product select for one multiplier digit
module pp_select #(
  parameter int RADIX_BITS = 2,
  parameter int WIDTH      = 48
) (
  input  logic [RADIX_BITS-1:0] d,
  input  logic [WIDTH-1:0]      a_sh,
  output logic [WIDTH-1:0]      pp
);

  logic [1:0] d_ext;

  assign d_ext = 2'(d);

  // Digit 3 is built as 2a + a so the datapath needs only shifts and one adder.
  always_comb begin
    pp = '0;
    case (d_ext)
      2'd0: pp = '0;
      2'd1: pp = a_sh;
      2'd2: pp = a_sh << 1;
      2'd3: pp = (a_sh << 1) + a_sh;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - iterative shift-add multiplier; optional SHIFT_ADD_MULT_EARLY_TERM_EN
module shift_add_multiplier
  import mod_arith_pkg::*;
#(
  parameter int A_WIDTH    = Q_WIDTH,
  parameter int B_WIDTH    = Q_WIDTH,
  parameter int PROD_WIDTH = DATA_WIDTH,
  parameter int RADIX_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [A_WIDTH-1:0]    a_in,
  input  logic [B_WIDTH-1:0]    b_in,
  output logic                  busy,
  output logic                  done,
  output logic [PROD_WIDTH-1:0] product_out
);

  localparam int N      = iter_count(B_WIDTH, RADIX_BITS);
  localparam int ITER_W = $clog2(N + 1);

  if (PROD_WIDTH < A_WIDTH + B_WIDTH + 2) begin : g_bad_width
    $error("PROD_WIDTH too narrow for operand widths");
  end
  if (RADIX_BITS < 1 || RADIX_BITS > 2) begin : g_bad_radix
    $error("RADIX_BITS must be 1 or 2");
  end

  state_e                state_q, state_d;
  logic [PROD_WIDTH-1:0] acc_q, acc_d;
  logic [PROD_WIDTH-1:0] a_sh_q, a_sh_d;
  logic [PROD_WIDTH-1:0] prod_q, prod_d;
  logic [B_WIDTH-1:0]    b_sh_q, b_sh_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  done_q, done_d;
  logic [PROD_WIDTH-1:0] pp;
  logic [B_WIDTH-1:0]    b_next;
  logic                  last_iter;

  pp_select #(
    .RADIX_BITS(RADIX_BITS),
    .WIDTH     (PROD_WIDTH)
  ) u_pp_select (
    .d   (b_sh_q[RADIX_BITS-1:0]),
    .a_sh(a_sh_q),
    .pp  (pp)
  );

  assign b_next = b_sh_q >> RADIX_BITS;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain; the product is already complete.
  assign last_iter = (iter_q == ITER_W'(N - 1)) || (b_next == '0);
`else
  assign last_iter = (iter_q == ITER_W'(N - 1));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    iter_d  = iter_q;
    prod_d  = prod_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_sh_d  = PROD_WIDTH'(a_in);
          b_sh_d  = b_in;
          acc_d   = '0;
          iter_d  = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        acc_d  = acc_q + pp;
        a_sh_d = a_sh_q << RADIX_BITS;
        b_sh_d = b_next;
        iter_d = iter_q + ITER_W'(1);
        if (last_iter) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        prod_d  = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      iter_q  <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      iter_q  <= iter_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign product_out = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

  typedef struct {
    logic [47:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [22:0] a_in = '0;
  logic [22:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [47:0] product_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  shift_add_multiplier dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .product_out(product_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [22:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    int          it;
    logic [22:0] t;
    it = 1;
    t  = b >> 2;
    while (t != 0) begin
      it++;
      t = t >> 2;
    end
    return it + 1;
`else
    return 13;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=%0d required=none at cycle %0d", product_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", 64'(product_out), 64'(e.prod));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        check("done_pulse_prev_low", 64'(prev_done), 64'd0);
      end
    end
    prev_done <= done;
  end

  // Call just after a negedge; the following posedge is the accepting edge E.
  task automatic do_start(input logic [22:0] a, input logic [22:0] b, input logic [47:0] prod);
    exp_t e;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    e.prod = prod;
    e.cyc  = cyc + 1 + exp_lat(b);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in  = 23'h5a5a5;
    b_in  = 23'h3c3c3;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_start(23'd3, 23'd5, 48'd15);
    wait_idle();
    do_start(23'd8388607, 23'd8388607, 48'd70368727400449);
    wait_idle();
    do_start(23'd8380416, 23'd8380416, 48'd70231372333056);
    wait_idle();
    do_start(23'd0, 23'd8380416, 48'd0);
    wait_idle();
    do_start(23'd8380416, 23'd0, 48'd0);
    wait_idle();

    // Back-to-back: second start lands in the first product's done cycle.
    do_start(23'd7, 23'd9, 48'd63);
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL b2b_done_timeout actual=%0d required=1", done);
      end
    end
    do_start(23'd2, 23'd11, 48'd22);
    wait_idle();

    // Start at E+5 with new operands must be ignored.
    do_start(23'd100, 23'd200, 48'd20000);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a_in  = 23'd5;
    b_in  = 23'd6;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset at E+6 discards the in-flight multiply.
    start = 1'b1;
    a_in  = 23'd11;
    b_in  = 23'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_product", 64'(product_out), 64'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_product", 64'(product_out), 64'd0);

    do_start(23'd4, 23'd4, 48'd16);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
